// File: rtl/ysyx_22050612_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_ifu -- instruction fetch unit of the multi-cycle RV64 core.
//
// Owns the architectural PC. Each step fetches one instruction from memory,
// hands it with its PC to decode/execute, then waits for execute to return
// the next PC (dnpc). There is no speculation: one instruction in flight.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready  fetch request handshake, imem_req_addr = pc
//   imem_rsp_valid        single-cycle response pulse with imem_rsp_data and
//                         imem_rsp_err (access fault)
//   inst_valid/ready      instruction handoff to downstream, carrying inst,
//                         inst_pc and inst_fault (misaligned PC or access fault)
//   npc_valid, npc        next PC committed by execute (single-cycle pulse)
//   perf_fetch_cnt        (optional) instructions handed downstream
//   perf_stall_cnt        (optional) cycles waiting on memory
//
// Handshake rule for every valid/ready pair in this block: a transfer happens
// on the rising edge where valid and ready are both 1; while valid is 1 and
// ready is 0 the payload is held unchanged.
//
// Optional feature: define YSYX_22050612_IFU_PERF_CNT_EN to add the two 64-bit
// performance counters. Without it the ports and counters are absent and the
// fetch behaviour is identical.
// ---------------------------------------------------------------------------
module ysyx_22050612_ifu #(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              imem_rsp_err,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_fault,
   input  logic              npc_valid,
   input  logic [ADDR_W-1:0] npc
`ifdef YSYX_22050612_IFU_PERF_CNT_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [63:0]       perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      NPC  = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [INST_W-1:0] inst_q;
   logic              fault_q;
   logic              misaligned;

   // pc is a register, so this flag is registered state: an address that
   // arrives misaligned is known the moment it enters REQ, and no request
   // is ever presented to memory for it.
   assign misaligned = |pc_q[1:0];

   // Valid outputs depend on registered state only, never on an input.
   assign imem_req_valid = (state_q == REQ) && !misaligned;
   assign inst_valid     = (state_q == HOLD);
   assign imem_req_addr  = pc_q;
   assign inst_pc        = pc_q;
   assign inst           = inst_q;
   assign inst_fault     = fault_q;

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (misaligned)          state_d = HOLD;
            else if (imem_req_ready) state_d = WAIT;
         end
         WAIT: if (imem_rsp_valid) state_d = HOLD;
         HOLD: if (inst_ready)     state_d = NPC;
         NPC:  if (npc_valid)      state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // PC and the instruction payload. The response is only sampled in WAIT,
   // which the request handshake enters one cycle later, so a response can
   // never be taken in the same cycle as its request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         if (state_q == REQ && misaligned) begin
            inst_q  <= '0;
            fault_q <= 1'b1;
         end
         if (state_q == WAIT && imem_rsp_valid) begin
            inst_q  <= imem_rsp_data;
            fault_q <= imem_rsp_err;
         end
         // npc is taken verbatim; alignment is execute's responsibility.
         if (state_q == NPC && npc_valid) begin
            pc_q <= npc;
         end
      end
   end

`ifdef YSYX_22050612_IFU_PERF_CNT_EN
   logic [63:0] fetch_cnt_q;
   logic [63:0] stall_cnt_q;

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;

   // Both counters wrap naturally at 2^64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == HOLD && inst_ready) begin
            fetch_cnt_q <= fetch_cnt_q + 64'd1;
         end
         if ((state_q == REQ && !imem_req_ready) || state_q == WAIT) begin
            stall_cnt_q <= stall_cnt_q + 64'd1;
         end
      end
   end
`endif

endmodule
